pci_bus_arbiter: RTL
====================

# pci_bus_arbiter

Central PCI bus arbiter for the PCI module. It takes active-low REQ# lines from up to N masters and drives active-low GNT# lines using round-robin priority. It uses hidden arbitration, parks the bus on a fixed master, and revokes a grant when the granted master never starts a transaction. It watches FRAME#/IRDY# to track the current bus owner and to detect when the bus is idle.

## Interface
- N_MASTERS, 4: number of requesters (2..8)
- PARK_ID, 0: master granted when no one requests
- GNT_TIMEOUT, 16: idle cycles a granted master has to assert FRAME# before the grant is revoked (≥2)
- clk  in  1  bus clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- req_n  in  N_MASTERS  request, active low, bit i = master i
- frame_n  in  1  PCI FRAME#, active low
- irdy_n  in  1  PCI IRDY#, active low
- gnt_n  out  N_MASTERS  grant, active low, registered
- owner  out  clog2(N_MASTERS)  index of the master owning the current transaction
- owner_vld  out  1  a transaction is in progress; owner is valid
- bus_idle  out  1  registered frame_n & irdy_n
- gnt_timeout  out  1  one-cycle pulse when a grant is revoked by timeout
- proto_err  out  1  one-cycle pulse when FRAME# starts with no grant presented the previous cycle

## Operation
- Idle: frame_n=1 and irdy_n=1. prev_idle is the previous cycle's idle value. Transaction start: prev_idle=1 and frame_n=0.
- ptr holds the last served master. Next target: the first i with req_n[i]=0 scanning ptr+1, ptr+2, … modulo N.
- At most one gnt_n bit is ever low. Any change of granted master passes through one cycle with all gnt_n=1.
- States: GAP, PARK, GNT, XFER. cur is the master currently granted.
- GAP: all gnt_n high.
  - Start detected: go to XFER; owner = master granted last cycle.
  - Else, any request: go to GNT, cur = next target.
  - Else: go to PARK.
- PARK: gnt_n[PARK_ID]=0.
  - Start: go to XFER, owner=PARK_ID.
  - Else req_n[PARK_ID]=0: go to GNT, cur=PARK_ID, no gap.
  - Else any other request: go to GAP.
- GNT: gnt_n[cur]=0.
  - Start: go to XFER, owner=cur, ptr=cur.
  - Else req_n[cur]=1: go to GAP.
  - Else timeout counter reaches GNT_TIMEOUT: go to GAP, pulse gnt_timeout, ptr=cur.
  - The counter clears on entry to GNT and on any busy cycle. It increments on each idle cycle in GNT.
- XFER: gnt_n[cur]=0.
  - Any other master requesting: go to GAP, then GNT to the next master while the bus is still busy (hidden arbitration). That master waits for idle and then starts.
  - Else bus returns idle: go to GNT if req_n[cur]=0, else go to GAP.
- owner_vld sets on a start and clears on the first idle cycle after it. owner holds its value until the next start.
- A start with no gnt_n bit low in the previous cycle:
  - pulse proto_err;
  - leave owner_vld=0;
  - keep state unchanged.
- Simultaneous start and request change in the same cycle: start takes precedence.

## Timing
- Reset values: gnt_n all 1, state GAP, ptr=N_MASTERS-1, owner=0, owner_vld=0, bus_idle=1, gnt_timeout=0, proto_err=0, counter 0.
- Reset mid-transaction returns all outputs to these values immediately. Bus activity already in progress is ignored until the next idle→start edge.
- Inputs are sampled at edge t; gnt_n, owner, owner_vld and pulses update at edge t (visible in cycle t+1).
- Request-to-grant latency:
  - from PARK via GAP: 2 cycles;
  - from PARK for PARK_ID itself: 1 cycle;
  - same master back-to-back from XFER: 0 cycles (grant held).
- Handover always costs exactly one all-high cycle.
- Timeout fires on the edge where the GNT_TIMEOUT-th consecutive idle granted cycle is sampled.

## Test plan
- After reset, no requests: gnt_n=4'b1111 for 1 cycle, then 4'b1110 (park on 0); owner_vld=0.
- req_n=4'b0101 held (masters 1 and 3); each master runs one FRAME# transaction per grant and holds req low. Required grant order: 1, 3, 1, 3; one all-high cycle between grants; owner matches at each start.
- Master 2 is in XFER and master 0 asserts req: gnt_n → 1111 → 1110 while frame_n is still low. Master 0's start after idle gives owner=0.
- Master 3 granted and holds req, never asserts FRAME#, bus idle: gnt_timeout pulses after 16 cycles; gnt_n → 1111, then other requesters are served with 3 at lowest priority.
- frame_n falls while gnt_n=1111 for ≥2 cycles: proto_err pulses one cycle, owner_vld stays 0.
- Assert rst during XFER with gnt_n=1011: gnt_n=1111 and owner_vld=0 immediately, before the next clock.

Source files
------------

// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: round-robin grants with hidden arbitration,
// bus parking on PARK_ID, and grant revocation when the granted master
// never starts a transaction.
module pci_bus_arbiter #(
  parameter int N_MASTERS   = 4,
  parameter int PARK_ID     = 0,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_MASTERS-1:0]         req_n,
  input  logic                         frame_n,
  input  logic                         irdy_n,
  output logic [N_MASTERS-1:0]         gnt_n,
  output logic [$clog2(N_MASTERS)-1:0] owner,
  output logic                         owner_vld,
  output logic                         bus_idle,
  output logic                         gnt_timeout,
  output logic                         proto_err
);

  localparam int IW = $clog2(N_MASTERS);
  localparam int CW = $clog2(GNT_TIMEOUT);
  localparam logic [IW-1:0]        PARK_IDX  = IW'(PARK_ID);
  localparam logic [N_MASTERS-1:0] PARK_MASK = N_MASTERS'(1) << PARK_ID;

  typedef enum logic [1:0] {GAP, PARK, GNT, XFER} state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        cur, cur_nxt;
  logic [IW-1:0]        ptr, ptr_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [IW-1:0]        owner_nxt;
  logic                 ovld_nxt, to_nxt, pe_nxt;
  logic [N_MASTERS-1:0] gnt_nxt, gnt_d;
  logic [N_MASTERS-1:0] req;
  logic [IW-1:0]        tgt, src, idx;
  logic                 idle, start, legal, any_req, other_req;

  // Index of the (single) low bit of a grant vector.
  function automatic logic [IW-1:0] low_idx(input logic [N_MASTERS-1:0] g);
    low_idx = '0;
    for (int i = 0; i < N_MASTERS; i++)
      if (!g[i]) low_idx = IW'(i);
  endfunction

  assign req       = ~req_n;
  assign idle      = frame_n & irdy_n;
  // bus_idle doubles as the previous cycle's idle value
  assign start     = bus_idle & ~frame_n;
  assign any_req   = |req;
  assign other_req = |(req & ~(N_MASTERS'(1) << cur));
  // A start is legitimate if some master saw a grant this cycle or the one before.
  assign legal     = ~&gnt_n | ~&gnt_d;
  assign src       = (~&gnt_n) ? low_idx(gnt_n) : low_idx(gnt_d);

  // Round-robin target: first requester after ptr, wrapping modulo N.
  always_comb begin
    tgt = ptr;
    idx = '0;
    for (int k = N_MASTERS; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % N_MASTERS);
      if (req[idx]) tgt = idx;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= GAP;
    else     state <= state_nxt;
  end

  // Next-state and next datapath values; a bus start outranks request changes.
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    owner_nxt = owner;
    ovld_nxt  = owner_vld;
    to_nxt    = 1'b0;
    pe_nxt    = 1'b0;
    if (start && !legal) begin
      pe_nxt = 1'b1;
    end else if (start) begin
      state_nxt = XFER;
      cur_nxt   = src;
      owner_nxt = src;
      ovld_nxt  = 1'b1;
      if (state == GNT) ptr_nxt = cur;
    end else begin
      if (idle) ovld_nxt = 1'b0;
      case (state)
        GAP: begin
          if (any_req) begin
            state_nxt = GNT;
            cur_nxt   = tgt;
            cnt_nxt   = '0;
          end else begin
            state_nxt = PARK;
            cur_nxt   = PARK_IDX;
          end
        end
        PARK: begin
          if (req[PARK_ID]) begin
            state_nxt = GNT;
            cur_nxt   = PARK_IDX;
            cnt_nxt   = '0;
          end else if (any_req) begin
            state_nxt = GAP;
          end
        end
        GNT: begin
          if (!req[cur]) begin
            state_nxt = GAP;
          end else if (!idle) begin
            cnt_nxt = '0;
          end else if (cnt == CW'(GNT_TIMEOUT - 1)) begin
            state_nxt = GAP;
            to_nxt    = 1'b1;
            ptr_nxt   = cur;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        XFER: begin
          if (other_req) begin
            state_nxt = GAP;
          end else if (idle) begin
            state_nxt = req[cur] ? GNT : GAP;
            cnt_nxt   = '0;
          end
        end
        default: state_nxt = GAP;
      endcase
    end
  end

  // Grant decode from the next state, so gnt_n comes straight from a flop.
  always_comb begin
    gnt_nxt = '1;
    case (state_nxt)
      PARK:      gnt_nxt = ~PARK_MASK;
      GNT, XFER: gnt_nxt = ~(N_MASTERS'(1) << cur_nxt);
      default:   gnt_nxt = '1;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_n       <= '1;
      gnt_d       <= '1;
      cur         <= PARK_IDX;
      ptr         <= IW'(N_MASTERS - 1);
      cnt         <= '0;
      owner       <= '0;
      owner_vld   <= 1'b0;
      bus_idle    <= 1'b1;
      gnt_timeout <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      gnt_n       <= gnt_nxt;
      gnt_d       <= gnt_n;
      cur         <= cur_nxt;
      ptr         <= ptr_nxt;
      cnt         <= cnt_nxt;
      owner       <= owner_nxt;
      owner_vld   <= ovld_nxt;
      bus_idle    <= idle;
      gnt_timeout <= to_nxt;
      proto_err   <= pe_nxt;
    end
  end

endmodule
